// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one multiplier between two clients
// Optional WAIT timeout abort enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_start,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_busy,
  output logic               req0_done,
  output logic               req0_err,
  output logic [2*WIDTH-1:0] req0_result,
  input  logic               req1_start,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_busy,
  output logic               req1_done,
  output logic               req1_err,
  output logic [2*WIDTH-1:0] req1_result,
  output logic               mul_clear,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_q;
  logic               pend0_q, pend1_q;
  logic [WIDTH-1:0]   a0_q, b0_q, a1_q, b1_q;
  logic               grant_q, last_grant_q;
  logic               mul_clear_q, mul_start_q;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic               done0_q, done1_q, err0_q, err1_q;
  logic [2*WIDTH-1:0] res0_q, res1_q;

  logic accept0_d, accept1_d, grant_d;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] cnt_q;
`else
  // TIMEOUT only matters when the timeout feature is compiled in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    accept0_d = req0_start && !pend0_q;
    accept1_d = req1_start && !pend1_q;
    // With both waiting, the client that was not served last wins.
    if (pend0_q && pend1_q) grant_d = ~last_grant_q;
    else                    grant_d = pend1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      a0_q         <= '0;
      b0_q         <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mul_clear_q  <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      res0_q       <= '0;
      res1_q       <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mul_clear_q <= 1'b0;
      if (accept0_d) begin
        pend0_q <= 1'b1;
        a0_q    <= req0_a;
        b0_q    <= req0_b;
      end
      if (accept1_d) begin
        pend1_q <= 1'b1;
        a1_q    <= req1_a;
        b1_q    <= req1_b;
      end
      case (state_q)
        S_IDLE: begin
          if (pend0_q || pend1_q) begin
            grant_q     <= grant_d;
            mul_clear_q <= 1'b1;
            mul_a_q     <= grant_d ? a1_q : a0_q;
            mul_b_q     <= grant_d ? b1_q : b0_q;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start_q <= 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
          cnt_q       <= '0;
`endif
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            mul_start_q  <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
            if (grant_q) begin
              res1_q  <= mul_result;
              done1_q <= 1'b1;
              pend1_q <= 1'b0;
            end else begin
              res0_q  <= mul_result;
              done0_q <= 1'b1;
              pend0_q <= 1'b0;
            end
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abort: clear the stuck multiplier and hand back an errored zero result.
            mul_start_q  <= 1'b0;
            mul_clear_q  <= 1'b1;
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
            if (grant_q) begin
              res1_q  <= '0;
              done1_q <= 1'b1;
              err1_q  <= 1'b1;
              pend1_q <= 1'b0;
            end else begin
              res0_q  <= '0;
              done0_q <= 1'b1;
              err0_q  <= 1'b1;
              pend0_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_busy   = pend0_q;
  assign req1_busy   = pend1_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_err    = err0_q;
  assign req1_err    = err1_q;
  assign req0_result = res0_q;
  assign req1_result = res1_q;
  assign mul_clear   = mul_clear_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;

endmodule
